// File: rtl/efuse_rw_ctrl.sv
// rtl/efuse_rw_ctrl.sv - Wishbone eFuse program/read controller with optional self-test
//
// Wishbone slave in front of a WORDS x 32 one-time-programmable fuse array.
// Fuse bits only ever go 0->1. Programming needs the PROG_EN unlock bit.
// When EFUSE_SELFTEST_EN is defined, a program/readback self-test is compiled in.
// That self-test drives the sticky pass_o/fail_o flags.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i    Wishbone cycle / strobe
//   wb_we_i, wb_sel_i     write enable, byte lanes
//   wb_adr_i[8:0]         byte address: [8]=0 fuse word [7:2], [8]=1 control regs
//   wb_dat_i / wb_dat_o   write / read data (wb_dat_o is 0 outside read acks)
//   wb_ack_o              single-cycle acknowledge
//   busy_o                fuse read, program or self-test in progress
//   pass_o, fail_o        sticky self-test result flags
//
// Build option: EFUSE_SELFTEST_EN (undefined: START ignored, ST regs read 0, flags stay 0)
module efuse_rw_ctrl #(
  parameter int WORDS       = 64,
  parameter int ADDR_W      = 6,
  parameter int PROG_CYCLES = 8,
  parameter int READ_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [8:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        busy_o,
  output logic        pass_o,
  output logic        fail_o
);

`ifdef EFUSE_SELFTEST_EN
  localparam bit SELFTEST = 1'b1;
`else
  localparam bit SELFTEST = 1'b0;
`endif

  localparam int CNT_W = $clog2(PROG_CYCLES + READ_CYCLES + 1);
  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_PROG, S_PACK, S_ST_INIT, S_ST_PROG, S_ST_READ, S_ST_CHECK
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic [31:0]       mem [WORDS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wadr;
  logic [31:0]       mem_wdata;

  logic [ADDR_W-1:0] req_adr;
  logic [31:0]       req_bits;
  logic              prog_en, werr, pass_r, fail_r;
  logic [31:0]       st_pat, st_exp, st_rd;
  logic [ADDR_W-1:0] st_adr;
  logic              ack_d;
  logic [31:0]       dat_d;

  logic              req, take, start;
  logic [ADDR_W-1:0] adr_word;
  logic [5:0]        ctrl_off;
  logic [31:0]       sel_mask, ctrl_rdata;
  logic              unused_adr_lsb;

  // A new request is only taken while idle and not in the ack cycle of the
  // previous one, so a master still holding stb during its ack is not re-served.
  assign req            = wb_cyc_i & wb_stb_i;
  assign take           = req & ~wb_ack_o & (state == S_IDLE);
  assign adr_word       = wb_adr_i[ADDR_W+1:2];
  assign ctrl_off       = wb_adr_i[7:2];
  assign sel_mask       = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign start          = SELFTEST & take & wb_adr_i[8] & wb_we_i & (ctrl_off == 6'd0) & wb_dat_i[0];
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  assign busy_o = (state != S_IDLE);
  assign pass_o = pass_r;
  assign fail_o = fail_r;

  always_comb begin
    ctrl_rdata = '0;
    case (ctrl_off)
      6'd0:    ctrl_rdata[1]        = prog_en;
      6'd1:    ctrl_rdata[3:0]      = {werr, fail_r, pass_r, busy_o};
      6'd2:    ctrl_rdata           = st_pat;
      6'd3:    ctrl_rdata[ADDR_W-1:0] = st_adr;
      default: ctrl_rdata           = '0;
    endcase
  end

  // Bus-side counters start at 1 because the accepting edge is the first
  // cycle of the operation; self-test counters start at 0 after ST_INIT.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ack_d     = 1'b0;
    dat_d     = '0;
    mem_we    = 1'b0;
    mem_wadr  = req_adr;
    mem_wdata = mem[req_adr] | req_bits;
    case (state)
      S_IDLE: begin
        if (take) begin
          if (wb_adr_i[8]) begin
            ack_d = 1'b1;
            if (!wb_we_i) dat_d = ctrl_rdata;
            if (start) state_d = S_ST_INIT;
          end else if (!wb_we_i) begin
            state_d = S_READ;
            cnt_d   = CNT_W'(1);
          end else if (prog_en) begin
            state_d = S_PROG;
            cnt_d   = CNT_W'(1);
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (cnt == READ_LAST) begin
          state_d = S_IDLE;
          ack_d   = req;
          dat_d   = req ? mem[req_adr] : '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_PROG: begin
        if (cnt == PROG_LAST) begin
          mem_we  = 1'b1;
          state_d = S_PACK;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_PACK: begin
        ack_d   = req;
        state_d = S_IDLE;
      end
      S_ST_INIT: begin
        state_d = S_ST_PROG;
        cnt_d   = '0;
      end
      S_ST_PROG: begin
        mem_wadr  = st_adr;
        mem_wdata = mem[st_adr] | st_pat;
        if (cnt == PROG_LAST) begin
          mem_we  = 1'b1;
          state_d = S_ST_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_ST_READ: begin
        if (cnt == READ_LAST) state_d = S_ST_CHECK;
        else                  cnt_d   = cnt + 1'b1;
      end
      S_ST_CHECK: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      req_adr  <= '0;
      req_bits <= '0;
      prog_en  <= 1'b0;
      werr     <= 1'b0;
      st_pat   <= '0;
      st_adr   <= '0;
      st_exp   <= '0;
      st_rd    <= '0;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      wb_ack_o <= ack_d;
      wb_dat_o <= dat_d;
      if (take && !wb_adr_i[8]) begin
        req_adr  <= adr_word;
        req_bits <= wb_dat_i & sel_mask;
      end
      if (take && !wb_adr_i[8] && wb_we_i && !prog_en) werr <= 1'b1;
      if (take && wb_adr_i[8] && wb_we_i) begin
        case (ctrl_off)
          6'd0: begin
            prog_en <= wb_dat_i[1];
            if (wb_dat_i[2]) werr <= 1'b0;
          end
          6'd2:    if (SELFTEST) st_pat <= wb_dat_i;
          6'd3:    if (SELFTEST) st_adr <= wb_dat_i[ADDR_W-1:0];
          default: ;
        endcase
      end
      if (start) begin
        pass_r <= 1'b0;
        fail_r <= 1'b0;
      end
      // Expected value is captured from the same OR that is written, so a
      // stuck or dropped fuse write shows up as a readback difference.
      if (state == S_ST_PROG && cnt == PROG_LAST) st_exp <= mem_wdata;
      if (state == S_ST_READ && cnt == READ_LAST) st_rd  <= mem[st_adr];
      if (state == S_ST_CHECK) begin
        pass_r <= (st_rd == st_exp);
        fail_r <= (st_rd != st_exp);
      end
    end
  end

  // Fuse storage has no reset; a reset mid-program leaves mem_we low.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wadr] <= mem_wdata;
  end

endmodule

// File: tb/tb_efuse_rw_ctrl.sv
// tb/tb_efuse_rw_ctrl.sv - randomized self-checking bench for efuse_rw_ctrl
module tb_efuse_rw_ctrl;
  localparam int PROG_CYCLES = 8;
  localparam int READ_CYCLES = 2;
`ifdef EFUSE_SELFTEST_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [8:0]  wb_adr_i = 9'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, busy_o, pass_o, fail_o;

  always #5 clock = ~clock;

  efuse_rw_ctrl dut (
    .clock(clock), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] fuse_m [64];
  logic        m_prog_en, m_werr, m_pass, m_fail;
  logic [31:0] m_st_pat;
  logic [5:0]  m_st_adr;
  time         last_ack_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++)
      if (sel[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  function automatic logic [31:0] ctrl_model(input int off);
    case (off)
      0:       return m_prog_en ? 32'h2 : 32'h0;
      1:       return {28'd0, m_werr, m_fail, m_pass, 1'b0};
      2:       return ST ? m_st_pat : 32'h0;
      3:       return ST ? {26'd0, m_st_adr} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd, output int lat,
                     output logic busy1);
    logic got;
    got = 1'b0; rd = 32'h0; lat = -1; busy1 = 1'b0;
    @(negedge clock);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    for (int i = 1; i <= 64 && !got; i++) begin
      @(negedge clock);
      if (i == 1) busy1 = busy_o;
      if (wb_ack_o) begin
        got = 1'b1; lat = i; rd = wb_dat_o; last_ack_t = $time;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("ack_seen", 32'(got), 32'h1);
    @(negedge clock);
    check("ack_single", 32'(wb_ack_o), 32'h0);
    check("dat_idle", wb_dat_o, 32'h0);
  endtask

  task automatic do_op(input string tag, input logic we, input logic [8:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] exp_d, rd;
    int          exp_lat, lat, w;
    logic        busy1;
    w = int'(adr[7:2]);
    exp_d = 32'h0;
    if (!adr[8]) begin
      if (!we) begin exp_lat = READ_CYCLES; exp_d = fuse_m[w]; end
      else     exp_lat = m_prog_en ? PROG_CYCLES + 1 : 1;
    end else begin
      exp_lat = 1;
      if (!we) exp_d = ctrl_model(w);
    end
    bus(we, adr, dat, sel, rd, lat, busy1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dat"}, rd, exp_d);
    if (!adr[8] && exp_lat > 1) check({tag, "_busy"}, 32'(busy1), 32'h1);
    if (we) begin
      if (!adr[8]) begin
        if (m_prog_en) fuse_m[w] = fuse_m[w] | (dat & lane_mask(sel));
        else           m_werr = 1'b1;
      end else begin
        case (w)
          0: begin
            if (ST && dat[0]) begin m_pass = 1'b0; m_fail = 1'b0; end
            m_prog_en = dat[1];
            if (dat[2]) m_werr = 1'b0;
          end
          2:       m_st_pat = dat;
          3:       m_st_adr = dat[5:0];
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    int          kind;
    logic [8:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        we, ack_seen;

    for (int i = 0; i < 64; i++) fuse_m[i] = 32'h0;
    m_prog_en = 1'b0; m_werr = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
    m_st_pat = 32'h0; m_st_adr = 6'h0; last_ack_t = 0;

    repeat (3) @(negedge clock);
    check("rst_ack",  32'(wb_ack_o), 32'h0);
    check("rst_dat",  wb_dat_o,      32'h0);
    check("rst_busy", 32'(busy_o),   32'h0);
    check("rst_pass", 32'(pass_o),   32'h0);
    check("rst_fail", 32'(fail_o),   32'h0);
    reset = 1'b0;

    do_op("rd_w0",       1'b0, 9'h000, 32'h0,        4'hF);
    do_op("wr_locked",   1'b1, 9'h00C, 32'h0000A5A5, 4'hF);
    do_op("status_werr", 1'b0, 9'h104, 32'h0,        4'hF);
    do_op("rd_w3",       1'b0, 9'h00C, 32'h0,        4'hF);
    do_op("ctrl_unlock", 1'b1, 9'h100, 32'h6,        4'hF);
    do_op("status_clr",  1'b0, 9'h104, 32'h0,        4'hF);
    do_op("ctrl_rd",     1'b0, 9'h100, 32'h0,        4'hF);
    do_op("wr_w5_f0",    1'b1, 9'h014, 32'h000000F0, 4'hF);
    do_op("wr_w5_lane0", 1'b1, 9'h014, 32'hFFFFFF0F, 4'h1);
    do_op("rd_w5",       1'b0, 9'h014, 32'h0,        4'hF);
    do_op("wr_w5_zero",  1'b1, 9'h014, 32'h0,        4'hF);
    do_op("rd_w5_keep",  1'b0, 9'h014, 32'h0,        4'hF);
    do_op("unused_rd",   1'b0, 9'h1F0, 32'h0,        4'hF);

    do_op("st_pat_wr", 1'b1, 9'h108, 32'hDEADBEEF, 4'hF);
    do_op("st_adr_wr", 1'b1, 9'h10C, 32'd10,       4'hF);
    do_op("st_pat_rd", 1'b0, 9'h108, 32'h0,        4'hF);
    do_op("st_start",  1'b1, 9'h100, {29'd0, 1'b0, m_prog_en, 1'b1}, 4'hF);
`ifdef EFUSE_SELFTEST_EN
    check("st_busy", 32'(busy_o), 32'h1);
    for (int i = 0; i < 40 && !(pass_o || fail_o); i++) @(negedge clock);
    check("st_latency", 32'(($time - last_ack_t) / 10), 32'(PROG_CYCLES + READ_CYCLES + 2));
    check("st_pass", 32'(pass_o), 32'h1);
    check("st_fail", 32'(fail_o), 32'h0);
    check("st_done_idle", 32'(busy_o), 32'h0);
    fuse_m[m_st_adr] = fuse_m[m_st_adr] | m_st_pat;
    m_pass = 1'b1;
`else
    repeat (20) @(negedge clock);
    check("st_off_busy", 32'(busy_o), 32'h0);
    check("st_off_pass", 32'(pass_o), 32'h0);
    check("st_off_fail", 32'(fail_o), 32'h0);
`endif
    do_op("st_word_rd", 1'b0, 9'h028, 32'h0, 4'hF);
    do_op("st_status",  1'b0, 9'h104, 32'h0, 4'hF);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      we   = 1'b0;
      if (kind <= 3) begin
        a = {1'b0, 6'($urandom_range(0, 62)), 2'b00};
      end else if (kind <= 6) begin
        a = {1'b0, 6'($urandom_range(0, 62)), 2'b00}; we = 1'b1;
      end else if (kind == 7) begin
        a = 9'h100; we = 1'b1;
`ifdef EFUSE_SELFTEST_EN
        d[0] = 1'b0;
`endif
      end else if (kind == 8) begin
        a = {1'b1, 6'($urandom_range(0, 7)), 2'b00};
      end else begin
        a = {1'b1, 6'($urandom_range(1, 7)), 2'b00}; we = 1'b1;
      end
      do_op("rnd", we, a, d, s);
    end

    do_op("prep_unlock", 1'b1, 9'h100, 32'h2, 4'hF);
    @(negedge clock);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 9'h0FC; wb_dat_i = 32'hFFFFFFFF; wb_sel_i = 4'hF;
    repeat (4) @(negedge clock);
    check("mid_busy", 32'(busy_o), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_o),   32'h0);
    check("mid_rst_ack",  32'(wb_ack_o), 32'h0);
    @(negedge clock);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    reset = 1'b0;
    m_prog_en = 1'b0; m_werr = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
    m_st_pat = 32'h0; m_st_adr = 6'h0;
    ack_seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (wb_ack_o) ack_seen = 1'b1;
    end
    check("mid_no_ack", 32'(ack_seen), 32'h0);
    do_op("mid_word", 1'b0, 9'h0FC, 32'h0, 4'hF);
    do_op("mid_ctrl", 1'b0, 9'h100, 32'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/efuse_rw_ctrl.md
# efuse_rw_ctrl

Wishbone-slave controller for a 64×32 one-time-programmable eFuse array, with optional built-in program/readback self-test. It sits on the user-project Wishbone bus next to the management SoC. Firmware loaded from SPI flash programs and reads fuse words through it. Self-test results go out on two pad-level flags: `pass_o` (success) and `fail_o` (failure).

## Interface
- `WORDS`, 64: number of 32-bit fuse words.
- `ADDR_W`, 6: word address width; log2(`WORDS`).
- `PROG_CYCLES`, 8: clock cycles per program operation.
- `READ_CYCLES`, 2: clock cycles per fuse read.

Ports:
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wb_cyc_i` in 1: Wishbone cycle.
- `wb_stb_i` in 1: Wishbone strobe.
- `wb_we_i` in 1: write enable.
- `wb_sel_i` in 4: byte lanes.
- `wb_adr_i` in 9: byte address within a 512 B window.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `busy_o` out 1: a program, read or self-test is in progress.
- `pass_o` out 1: sticky, self-test passed.
- `fail_o` out 1: sticky, self-test failed.

## Operation
Address decode:
- `wb_adr_i[8]`=0: fuse word `wb_adr_i[7:2]`.
- `wb_adr_i[8]`=1: control registers.

Control registers:
- 0x100 CTRL:
  - bit0 START: write-1 pulse, reads 0.
  - bit1 PROG_EN: read/write unlock.
- 0x104 STATUS, read-only:
  - bit0 busy
  - bit1 pass
  - bit2 fail
  - bit3 WERR, sticky; cleared by writing 1 to CTRL bit2.
- 0x108 ST_PAT: self-test pattern, read/write.
- 0x10C ST_ADR: self-test word address, bits[5:0].
- Other control offsets read 0; writes to them are ignored; acked after 1 cycle.

Fuse array:
- Storage is not reset. Simulation initial value is all zero.
- Bits only transition 0→1: new = old | (wb_dat_i & byte mask from `wb_sel_i`).
- Fuse write with PROG_EN=0: no array change, WERR set, acked after 1 cycle.
- Fuse read returns the stored word.

Self-test:
- Idle → PROG → READ → CHECK → Idle.
- Writes `ST_PAT` into word `ST_ADR` using fuse-write semantics, regardless of PROG_EN.
- Reads the word back and compares it with the expected value (old | ST_PAT).
- Equal: set `pass_o`; otherwise set `fail_o`.
- `pass_o` and `fail_o` are mutually exclusive. A new START clears both.
- START while busy is ignored.

## Timing
- All outputs reset to 0: `wb_ack_o`, `wb_dat_o`, `busy_o`, `pass_o`, `fail_o`. Registers reset to 0.
- Control register access: ack 1 cycle after `wb_cyc_i & wb_stb_i` is sampled.
- Fuse read: ack `READ_CYCLES` cycles after request; `wb_dat_o` is valid in the ack cycle.
- Fuse program: array word updates atomically on the final program cycle; ack follows 1 cycle later (`PROG_CYCLES`+1 total).
- `wb_ack_o` is high for exactly one cycle. `wb_dat_o` is 0 outside read-ack cycles.
- Strobe dropped before ack: the internal operation still completes, but no ack is issued.
- While self-test is busy, Wishbone requests stall (no ack) until it finishes, then are served in order.
- `busy_o` is high from the cycle after a request or START until the cycle of ack or completion.
- Self-test latency: `PROG_CYCLES` + `READ_CYCLES` + 2 cycles from START write ack to pass/fail assertion.
- Reset during program: word unchanged, FSM back to Idle, no ack.

## Configuration
- `EFUSE_SELFTEST_EN` defined: self-test FSM and registers 0x108/0x10C are compiled in.
- Not defined:
  - START is ignored.
  - 0x108/0x10C read 0.
  - `pass_o`/`fail_o` tied 0.

## Test plan
- Reset, then read fuse word 0 → 0x00000000 acked after 2 cycles; all outputs 0 during reset.
- Write 0x0000A5A5 to word 3 with PROG_EN=0 → word stays 0, WERR=1, ack after 1 cycle.
- With PROG_EN=1: write 0x000000F0 to word 5, then 0x0000000F with `wb_sel_i`=0001, then read → 0x000000FF; program ack after 9 cycles.
- Write 0 to a programmed word → value unchanged (no 1→0 transitions).
- Self-test with ST_PAT=0xDEADBEEF, ST_ADR=10, START → `pass_o`=1 after 12 cycles, `fail_o`=0; word 10 reads 0xDEADBEEF.
- Assert reset mid-program → target word unchanged, `busy_o`=0, no ack.
